cpu_sequencer: RTL and testbench

Phase sequencer for the 8-bit RISC core. It steps every instruction through a fixed 8-phase fetch/execute cycle and decodes the 3-bit opcode into per-phase control strobes for the program counter, instruction register, accumulator, ALU and 32x8 memory. It also handles halt/resume run control and counts retired instructions. It sits between the IR opcode field and the datapath/memory enables.

---
 rtl/cpu_sequencer.sv | 149 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Eight-phase fetch/execute sequencer with opcode decode, halt/resume and a retired-instruction count.
// Optional single-step run control is built when CTRL_SINGLE_STEP_EN is defined.
module cpu_sequencer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       opcode,
   input  logic             zero,
   input  logic             resume,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic             step_mode,
   input  logic             step,
`endif
   output logic             sel,
   output logic             rd,
   output logic             wr,
   output logic             ld_ir,
   output logic             ld_ac,
   output logic             ld_pc,
   output logic             inc_pc,
   output logic             data_e,
   output logic             halt,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [1:0] {RST_IDLE, RUN, HALTED, WAIT_STEP} state_t;

   typedef enum logic [2:0] {
      OP_HLT = 3'b000, OP_SKZ = 3'b001, OP_ADD = 3'b010, OP_AND = 3'b011,
      OP_XOR = 3'b100, OP_LDA = 3'b101, OP_STO = 3'b110, OP_JMP = 3'b111
   } op_t;

   typedef struct packed {
      logic sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
   } ctl_t;

   localparam ctl_t FETCH0   = '{sel: 1'b1, default: 1'b0};
   localparam ctl_t HALT_CTL = '{halt: 1'b1, default: 1'b0};

   state_t state;
   op_t    op_q;
   ctl_t   ctl;

   // Strobes for the phase being entered; ph4 is decoded from the opcode being captured.
   function automatic ctl_t decode(input logic [2:0] ph, input op_t op, input logic z);
      ctl_t c;
      logic aluop;
      c     = '0;
      aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
      case (ph)
         3'd0: c.sel = 1'b1;
         3'd1: begin c.sel = 1'b1; c.rd = 1'b1; end
         3'd2, 3'd3: begin c.sel = 1'b1; c.rd = 1'b1; c.ld_ir = 1'b1; end
         3'd4: begin c.inc_pc = 1'b1; c.halt = (op == OP_HLT); end
         3'd5: c.rd = aluop;
         3'd6: begin
            c.rd     = aluop;
            c.inc_pc = (op == OP_SKZ) && z;
            c.ld_pc  = (op == OP_JMP);
            c.data_e = (op == OP_STO);
         end
         default: begin
            c.rd     = aluop;
            c.ld_ac  = aluop;
            c.ld_pc  = (op == OP_JMP);
            c.wr     = (op == OP_STO);
            c.data_e = (op == OP_STO);
         end
      endcase
      return c;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RST_IDLE;
         phase     <= '0;
         instr_cnt <= '0;
         ctl       <= '0;
         op_q      <= OP_HLT;
      end else begin
         case (state)
            RST_IDLE: begin
               state <= RUN;
               phase <= '0;
               ctl   <= FETCH0;
            end
            RUN: begin
               if (phase == 3'd7) begin
                  instr_cnt <= instr_cnt + CNT_W'(1);
                  phase     <= '0;
`ifdef CTRL_SINGLE_STEP_EN
                  if (step_mode) begin
                     state <= WAIT_STEP;
                     ctl   <= '0;
                  end else begin
                     ctl <= FETCH0;
                  end
`else
                  ctl <= FETCH0;
`endif
               end else if (phase == 3'd4 && op_q == OP_HLT) begin
                  state <= HALTED;
                  phase <= '0;
                  ctl   <= HALT_CTL;
               end else begin
                  if (phase == 3'd3)
                     op_q <= op_t'(opcode);
                  phase <= phase + 3'd1;
                  ctl   <= decode(phase + 3'd1, (phase == 3'd3) ? op_t'(opcode) : op_q, zero);
               end
            end
            HALTED: begin
               if (resume) begin
                  state <= RUN;
                  phase <= '0;
                  ctl   <= FETCH0;
               end
            end
`ifdef CTRL_SINGLE_STEP_EN
            WAIT_STEP: begin
               if (step || !step_mode) begin
                  state <= RUN;
                  phase <= '0;
                  ctl   <= FETCH0;
               end
            end
`endif
            default: begin
               state <= RST_IDLE;
               phase <= '0;
               ctl   <= '0;
            end
         endcase
      end
   end

   assign sel    = ctl.sel;
   assign rd     = ctl.rd;
   assign wr     = ctl.wr;
   assign ld_ir  = ctl.ld_ir;
   assign ld_ac  = ctl.ld_ac;
   assign ld_pc  = ctl.ld_pc;
   assign inc_pc = ctl.inc_pc;
   assign data_e = ctl.data_e;
   assign halt   = ctl.halt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: the driver queues hand-tabled per-cycle expectations, a monitor compares them.
// Counter is narrowed to 4 bits so wrap-around is reachable in a short run.
module tb_cpu_sequencer;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n, zero, resume;
   logic [2:0]    opcode;
   logic          sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
   logic [2:0]    phase;
   logic [CW-1:0] instr_cnt;
`ifdef CTRL_SINGLE_STEP_EN
   logic          step_mode, step;
`endif

   cpu_sequencer #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .resume(resume),
`ifdef CTRL_SINGLE_STEP_EN
      .step_mode(step_mode), .step(step),
`endif
      .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc),
      .inc_pc(inc_pc), .data_e(data_e), .halt(halt), .phase(phase), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3+9+CW-1:0] v;
      string             tag;
   } exp_t;

   exp_t          q[$];
   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] cnt_m;
   logic          sm;

   // Hand table, bit order {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
   function automatic logic [8:0] ref_strb(input logic [2:0] op, input int ph, input logic z);
      logic [8:0] s;
      s = 9'b000000000;
      case (ph)
         0: s = 9'b100000000;
         1: s = 9'b110000000;
         2, 3: s = 9'b110100000;
         4: s = (op == 3'b000) ? 9'b000000101 : 9'b000000100;
         default: begin
            case (op)
               3'b010, 3'b011, 3'b100, 3'b101:
                  s = (ph == 7) ? 9'b010010000 : 9'b010000000;
               3'b110: s = (ph == 7) ? 9'b001000010 : (ph == 6) ? 9'b000000010 : 9'b000000000;
               3'b001: s = (ph == 6 && z) ? 9'b000000100 : 9'b000000000;
               3'b111: s = (ph == 5) ? 9'b000000000 : 9'b000001000;
               default: s = 9'b000000000;
            endcase
         end
      endcase
      return s;
   endfunction

   task automatic edge_exp(input logic [2:0] ph, input logic [8:0] strb, input string tag);
      exp_t e;
      e.v   = {ph, strb, cnt_m};
      e.tag = tag;
      q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic run_partial(input logic [2:0] op, input logic z, input int last, input string name);
      opcode = op;
      zero   = z;
      for (int p = 1; p <= last; p++)
         edge_exp(3'(p), ref_strb(op, p, z), $sformatf("%s ph%0d", name, p));
   endtask

   task automatic run_instr(input logic [2:0] op, input logic z, input string name);
      run_partial(op, z, 7, name);
      cnt_m = cnt_m + 1'b1;
      if (sm)
         edge_exp(3'd0, 9'b000000000, {name, " wait_step"});
      else
         edge_exp(3'd0, 9'b100000000, {name, " retire"});
   endtask

   initial begin : monitor
      exp_t             e;
      logic [3+9+CW-1:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {phase, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, instr_cnt};
            checks++;
            if (act !== e.v) begin
               errors++;
               $display("FAIL %s: got ph/strb/cnt %b expected %b", e.tag, act, e.v);
            end
         end
      end
   end

   initial begin : driver
      rst_n = 1'b0; resume = 1'b0; zero = 1'b0; opcode = 3'b000;
      cnt_m = '0;   sm = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
      step_mode = 1'b0; step = 1'b0;
`endif
      edge_exp(3'd0, 9'b000000000, "reset");
      edge_exp(3'd0, 9'b000000000, "reset hold");
      rst_n = 1'b1;
      edge_exp(3'd0, 9'b100000000, "leave reset");

      run_instr(3'b010, 1'b0, "ADD");
      run_instr(3'b110, 1'b0, "STO");
      run_instr(3'b001, 1'b1, "SKZ z1");
      run_instr(3'b001, 1'b0, "SKZ z0");
      run_instr(3'b111, 1'b0, "JMP");
      run_instr(3'b011, 1'b0, "AND");
      run_instr(3'b100, 1'b0, "XOR");
      run_instr(3'b101, 1'b0, "LDA");

      // HLT; resume coinciding with the ph4->HALTED edge must be ignored
      run_partial(3'b000, 1'b0, 4, "HLT");
      resume = 1'b1;
      edge_exp(3'd0, 9'b000000001, "halted");
      resume = 1'b0;
      repeat (3) edge_exp(3'd0, 9'b000000001, "halted hold");
      resume = 1'b1;
      edge_exp(3'd0, 9'b100000000, "resume");
      resume = 1'b0;

      repeat (9) run_instr(3'b010, 1'b0, "ADD wrap");

      run_partial(3'b110, 1'b0, 6, "STO abort");
      rst_n = 1'b0;
      cnt_m = '0;
      edge_exp(3'd0, 9'b000000000, "reset mid STO");
      rst_n = 1'b1;
      edge_exp(3'd0, 9'b100000000, "restart");
      run_instr(3'b010, 1'b0, "ADD after reset");

`ifdef CTRL_SINGLE_STEP_EN
      step_mode = 1'b1;
      sm        = 1'b1;
      run_instr(3'b100, 1'b0, "XOR step");
      repeat (10) edge_exp(3'd0, 9'b000000000, "wait_step hold");
      step = 1'b1;
      edge_exp(3'd0, 9'b100000000, "step release");
      step = 1'b0;
      run_instr(3'b010, 1'b0, "ADD step");
      step_mode = 1'b0;
      sm        = 1'b0;
      edge_exp(3'd0, 9'b100000000, "step_mode drop");
`endif

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
